branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- EXEC-stage partner of the fetch-side branch predictor: resolves each branch against the prediction it carried down the pipe.
- Issues the front-end redirect and pipeline flush on a misprediction.
- Queues training updates (pc, target, outcome) back to the predictor over a valid/ready handshake.
- Sits between the EXEC ALU/compare logic and the predictor's update port.

Parameters:
- UPD_DEPTH, 4, entries in the predictor-update FIFO (power of two, >=2).
- FLUSH_CYCLES, 2, cycles `flush` is held after a mispredict (>=1).
- INSTR_BYTES, 4, fall-through increment for a not-taken branch.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- x_valid  in  1  EXEC slot holds a live instruction
- x_is_branch  in  1  instruction in EXEC is a branch
- x_pc  in  32  PC of the EXEC instruction
- x_taken  in  1  branch actually taken
- x_target  in  32  computed branch target
- x_pred_valid  in  1  fetch used a predictor hit for this instruction
- x_pred_addr  in  32  address predicted at fetch
- x_stall  out  1  resolver cannot accept a branch this cycle
- redirect_valid  out  1  one-cycle pulse: refetch from redirect_addr
- redirect_addr  out  32  correct next PC
- flush  out  1  squash younger instructions in FETCH/DECODE
- upd_valid  out  1  update entry available to predictor
- upd_ready  in  1  predictor accepts the update
- upd_pc  out  32  branch PC to train
- upd_target  out  32  actual target
- upd_taken  out  1  actual outcome for the 2-bit counter

Behaviour:
- Reset (async, any time, including mid-flush):
  - redirect_valid=0, redirect_addr=0, flush=0, upd_valid=0.
  - FIFO emptied; FSM forced to IDLE.
  - upd_pc, upd_target and upd_taken read 0.
- Accept condition: `accept = x_valid & x_is_branch & ~x_stall & (state==IDLE)`.
- Next-PC arithmetic (32-bit, wrap modulo 2^32):
  - actual = x_taken ? x_target : x_pc+INSTR_BYTES.
  - predicted = x_pred_valid ? x_pred_addr : x_pc+INSTR_BYTES.
  - mispredict = accept & (actual != predicted).
- FSM with states IDLE and FLUSH:
  - IDLE, on mispredict:
    - next cycle redirect_valid=1 for exactly one cycle, redirect_addr=actual.
    - flush=1; load down-counter with FLUSH_CYCLES-1; go to FLUSH.
  - FLUSH:
    - flush=1 while the counter is nonzero; decrement each cycle.
    - when the counter reaches 0, flush drops and the FSM returns to IDLE on the same edge.
    - total flush width = FLUSH_CYCLES cycles, starting the cycle after the mispredicting branch.
    - x_valid is ignored (wrong path): no accept, no FIFO push, no second redirect.
- Correct prediction: no redirect, no flush, 0-cycle penalty.
- redirect_addr holds its last value when redirect_valid=0.
- Update FIFO:
  - every accepted branch pushes {x_pc, actual target (x_target), x_taken}, taken or not.
  - head is presented on upd_*.
  - pop on upd_valid & upd_ready; upd_valid = ~empty, registered from FIFO state.
  - x_stall = full & ~(upd_valid & upd_ready) (combinational); upstream holds EXEC while x_stall=1.
  - simultaneous push and pop when full: allowed, occupancy unchanged.
  - push and pop when empty: entry becomes visible the next cycle (no fall-through).
  - pointers wrap modulo UPD_DEPTH; extra occupancy bit distinguishes full from empty.
- Non-branch instructions: no effect on any state.
- x_stall does not depend on FSM state; during FLUSH, accept is simply 0.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- When defined, adds two outputs, both reset to 0:
  - stat_branches [31:0]: increments on every accept.
  - stat_mispredicts [31:0]: increments on every mispredict.
  - both saturate at 0xFFFF_FFFF.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Correct taken prediction: reset; branch pc=0x100, taken, target=0x200, pred_valid=1, pred_addr=0x200 -> no redirect, no flush; next cycle upd_valid=1, upd_pc=0x100, upd_target=0x200, upd_taken=1.
- Not-taken but predicted taken: pc=0x40, x_taken=0, pred_valid=1, pred_addr=0x80 -> next cycle redirect_valid=1 for 1 cycle, redirect_addr=0x44; flush high exactly 2 cycles.
- Flush ignores wrong path: branch pc=0x300 presented during FLUSH -> no push, no redirect; FIFO occupancy unchanged.
- Backpressure: upd_ready=0, resolve 4 correct branches -> x_stall=1; a 5th branch is held. Raise upd_ready -> same-cycle accept of the 5th branch, FIFO order preserved 1..5.
- Wrap-around: pc=0xFFFF_FFFC not taken, pred_valid=1, pred_addr=0x10 -> redirect_addr=0x0000_0000.
- Reset mid-flush: assert reset in the 1st FLUSH cycle with 3 FIFO entries -> flush=0, upd_valid=0 immediately; after release a correct branch is accepted normally. With BRANCH_RESOLVER_STATS_EN, counters read 0.

Source files
------------

// File: rtl/branch_resolver.sv
// EXEC-stage branch resolver: mispredict redirect/flush plus a predictor-update FIFO.
// Optional saturating statistics counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int UPD_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int INSTR_BYTES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        x_valid,
  input  logic        x_is_branch,
  input  logic [31:0] x_pc,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  input  logic        x_pred_valid,
  input  logic [31:0] x_pred_addr,
  output logic        x_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        flush,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_entry_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_addr_q, redirect_addr_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  upd_entry_t         mem_q [UPD_DEPTH];
  upd_entry_t         head;

  logic        accept, mispredict, push, pop, empty, full;
  logic [31:0] fall_through, actual, predicted;

  assign fall_through = x_pc + 32'(INSTR_BYTES);
  assign actual       = x_taken ? x_target : fall_through;
  assign predicted    = x_pred_valid ? x_pred_addr : fall_through;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = upd_valid & upd_ready;
  assign x_stall = full & ~pop;
  assign push    = accept;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = redirect_addr_q;
    accept           = 1'b0;
    mispredict       = 1'b0;
    case (state_q)
      IDLE: begin
        accept     = x_valid & x_is_branch & ~x_stall;
        mispredict = accept & (actual != predicted);
        if (mispredict) begin
          state_d          = FLUSH;
          cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
          redirect_valid_d = 1'b1;
          redirect_addr_d  = actual;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
  end

  assign wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= '{pc: x_pc, target: x_target, taken: x_taken};
  end

  assign head           = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign upd_valid      = ~empty;
  assign upd_pc         = upd_valid ? head.pc     : '0;
  assign upd_target     = upd_valid ? head.target : '0;
  assign upd_taken      = upd_valid & head.taken;
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign flush          = (state_q == FLUSH);

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (accept && stat_branches_q != '1)        stat_branches_q    <= stat_branches_q + 32'd1;
      if (mispredict && stat_mispredicts_q != '1) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver: prediction outcomes, flush window,
// update FIFO backpressure/order, PC wrap-around and asynchronous reset mid-flush.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_valid, x_is_branch, x_taken, x_pred_valid;
  logic [31:0] x_pc, x_target, x_pred_addr;
  logic        x_stall, redirect_valid, flush, upd_valid, upd_ready, upd_taken;
  logic [31:0] redirect_addr, upd_pc, upd_target;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  branch_resolver dut (
    .clk            (clk),
    .reset          (reset),
    .x_valid        (x_valid),
    .x_is_branch    (x_is_branch),
    .x_pc           (x_pc),
    .x_taken        (x_taken),
    .x_target       (x_target),
    .x_pred_valid   (x_pred_valid),
    .x_pred_addr    (x_pred_addr),
    .x_stall        (x_stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .flush          (flush),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic pv, input logic [31:0] pa);
    x_valid      = 1'b1;
    x_is_branch  = 1'b1;
    x_pc         = pc;
    x_taken      = tk;
    x_target     = tgt;
    x_pred_valid = pv;
    x_pred_addr  = pa;
  endtask

  task automatic drive_idle();
    x_valid      = 1'b0;
    x_is_branch  = 1'b0;
    x_pc         = '0;
    x_taken      = 1'b0;
    x_target     = '0;
    x_pred_valid = 1'b0;
    x_pred_addr  = '0;
  endtask

  initial begin
    drive_idle();
    upd_ready = 1'b1;
    reset     = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_addr",  redirect_addr,       32'd0);
    check("rst_flush",          32'(flush),          32'd0);
    check("rst_upd_valid",      32'(upd_valid),      32'd0);
    check("rst_upd_pc",         upd_pc,              32'd0);
    check("rst_upd_target",     upd_target,          32'd0);
    check("rst_upd_taken",      32'(upd_taken),      32'd0);
    check("rst_x_stall",        32'(x_stall),        32'd0);
    #5 reset = 1'b0;
    step();

    // Correct taken prediction: no redirect, entry visible next cycle.
    upd_ready = 1'b0;
    drive_br(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    step();
    drive_idle();
    check("ok_taken_redirect", 32'(redirect_valid), 32'd0);
    check("ok_taken_flush",    32'(flush),          32'd0);
    check("ok_taken_upd_valid",32'(upd_valid),      32'd1);
    check("ok_taken_upd_pc",   upd_pc,              32'h100);
    check("ok_taken_upd_tgt",  upd_target,          32'h200);
    check("ok_taken_upd_tk",   32'(upd_taken),      32'd1);
    upd_ready = 1'b1;
    step();
    check("ok_taken_drained",  32'(upd_valid),      32'd0);

    // Not taken but predicted taken: redirect to fall-through, 2-cycle flush.
    drive_br(32'h40, 1'b0, 32'h1234, 1'b1, 32'h80);
    upd_ready = 1'b0;
    step();
    check("mp_redirect_valid", 32'(redirect_valid), 32'd1);
    check("mp_redirect_addr",  redirect_addr,       32'h44);
    check("mp_flush_c1",       32'(flush),          32'd1);
    // Wrong-path branch while flushing must be ignored.
    drive_br(32'h300, 1'b1, 32'h999, 1'b0, 32'h0);
    step();
    check("mp_redirect_pulse", 32'(redirect_valid), 32'd0);
    check("mp_redirect_hold",  redirect_addr,       32'h44);
    check("mp_flush_c2",       32'(flush),          32'd1);
    step();
    drive_idle();
    check("mp_flush_c3",       32'(flush),          32'd0);
    check("mp_no_2nd_redirect",32'(redirect_valid), 32'd0);
    check("mp_upd_pc",         upd_pc,              32'h40);
    check("mp_upd_tgt",        upd_target,          32'h1234);
    check("mp_upd_tk",         32'(upd_taken),      32'd0);
    upd_ready = 1'b1;
    step();
    check("wrong_path_not_pushed", 32'(upd_valid),  32'd0);

    // Correct not-taken, unpredicted: no redirect.
    drive_br(32'h600, 1'b0, 32'h700, 1'b0, 32'h0);
    upd_ready = 1'b0;
    step();
    drive_idle();
    check("nt_redirect",       32'(redirect_valid), 32'd0);
    check("nt_flush",          32'(flush),          32'd0);
    check("nt_upd_pc",         upd_pc,              32'h600);
    upd_ready = 1'b1;
    step();

    // Non-branch: no push, no redirect even if prediction disagrees.
    x_valid = 1'b1; x_is_branch = 1'b0; x_pc = 32'h700; x_taken = 1'b1;
    x_target = 32'h40; x_pred_valid = 1'b1; x_pred_addr = 32'h88;
    step();
    drive_idle();
    check("nonbr_redirect",    32'(redirect_valid), 32'd0);
    check("nonbr_upd_valid",   32'(upd_valid),      32'd0);

    // Backpressure: fill four entries, fifth is held until upd_ready rises.
    upd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_br(32'h1000 + 32'(i * 16), 1'b1, 32'h2000 + 32'(i * 16), 1'b1, 32'h2000 + 32'(i * 16));
      step();
    end
    drive_br(32'h1050, 1'b1, 32'h2050, 1'b1, 32'h2050);
    #1;
    check("bp_stall_full",     32'(x_stall),        32'd1);
    step();
    check("bp_stall_held",     32'(x_stall),        32'd1);
    check("bp_head_held",      upd_pc,              32'h1010);
    upd_ready = 1'b1;
    #1;
    check("bp_stall_release",  32'(x_stall),        32'd0);
    step();
    drive_idle();
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("bp_order_pc%0d", i),  upd_pc,     32'h1000 + 32'(i * 16));
      check($sformatf("bp_order_tgt%0d", i), upd_target, 32'h2000 + 32'(i * 16));
      step();
    end
    check("bp_drained",        32'(upd_valid),      32'd0);

    // Fall-through wraps modulo 2^32.
    drive_br(32'hFFFF_FFFC, 1'b0, 32'h7, 1'b1, 32'h10);
    step();
    drive_idle();
    check("wrap_redirect_valid", 32'(redirect_valid), 32'd1);
    check("wrap_redirect_addr",  redirect_addr,       32'h0);
    check("wrap_upd_pc",         upd_pc,              32'hFFFF_FFFC);
    step();
    step();
    check("wrap_flush_done",     32'(flush),          32'd0);

    // Reset during the first flush cycle with three queued entries.
    upd_ready = 1'b0;
    drive_br(32'h800, 1'b1, 32'h880, 1'b1, 32'h880);
    step();
    drive_br(32'h810, 1'b1, 32'h890, 1'b1, 32'h890);
    step();
    drive_br(32'h820, 1'b1, 32'h900, 1'b0, 32'h0);
    step();
    drive_idle();
    check("mid_flush_c1",      32'(flush),          32'd1);
    check("mid_upd_valid",     32'(upd_valid),      32'd1);
    check("mid_redirect_addr", redirect_addr,       32'h900);
    reset = 1'b1;
    #1;
    check("mid_rst_flush",     32'(flush),          32'd0);
    check("mid_rst_upd_valid", 32'(upd_valid),      32'd0);
    check("mid_rst_redirect",  32'(redirect_valid), 32'd0);
    check("mid_rst_addr",      redirect_addr,       32'd0);
    check("mid_rst_upd_pc",    upd_pc,              32'd0);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("mid_rst_stat_br",   stat_branches,       32'd0);
    check("mid_rst_stat_mp",   stat_mispredicts,    32'd0);
`endif
    #1 reset = 1'b0;
    step();
    check("post_rst_flush",    32'(flush),          32'd0);
    drive_br(32'hA00, 1'b1, 32'hB00, 1'b1, 32'hB00);
    step();
    drive_idle();
    check("post_rst_redirect", 32'(redirect_valid), 32'd0);
    check("post_rst_upd_valid",32'(upd_valid),      32'd1);
    check("post_rst_upd_pc",   upd_pc,              32'hA00);
    check("post_rst_upd_tgt",  upd_target,          32'hB00);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("post_rst_stat_br",  stat_branches,       32'd1);
    check("post_rst_stat_mp",  stat_mispredicts,    32'd0);
`endif
    step();
    check("post_rst_hold",     upd_pc,              32'hA00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
